// File: rtl/alu_sweep_pkg.sv
// Shared definitions for the ALU sweep master: opcodes, FSM encoding and the
// golden ALU model used when ALU_SWEEP_CHECK_EN is defined.
package alu_sweep_pkg;

    localparam int EXP_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_INC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_XNOR = 4'd14;
    localparam logic [3:0] OP_BUF  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operands arrive zero-extended; amask selects the operand width so the
    // bitwise ops are formed on operand bits only. Caller truncates to Y_W.
    function automatic logic [EXP_W-1:0] alu_expect(
        input logic [EXP_W-1:0] a,
        input logic [EXP_W-1:0] b,
        input logic [3:0]       cmd,
        input logic [EXP_W-1:0] amask
    );
        logic [EXP_W-1:0] r;
        case (cmd)
            OP_ADD:  r = a + b;
            OP_INC:  r = a + 32'd1;
            OP_SUB:  r = a - b;
            OP_DEC:  r = a - 32'd1;
            OP_MUL:  r = a * b;
            OP_DIV:  r = (b == 32'd0) ? 32'd0 : a / b;
            OP_SHL:  r = a << 1;
            OP_SHR:  r = a >> 1;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a & amask;
            OP_NAND: r = ~(a & b) & amask;
            OP_NOR:  r = ~(a | b) & amask;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b) & amask;
            OP_BUF:  r = a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sweep_master_if.sv
// ALU drive bus plus valid/ready result stream of the ALU sweep master.
interface alu_sweep_master_if #(
    parameter int A_W   = 8,
    parameter int CMD_W = 4,
    parameter int Y_W   = 16
);
    logic [A_W-1:0]   alu_a;
    logic [A_W-1:0]   alu_b;
    logic [CMD_W-1:0] alu_cmd;
    logic             alu_en;
    logic [Y_W-1:0]   alu_y;

    logic             res_valid;
    logic             res_ready;
    logic [A_W-1:0]   res_a;
    logic [A_W-1:0]   res_b;
    logic [CMD_W-1:0] res_cmd;
    logic [Y_W-1:0]   res_y;

    modport master (
        output alu_a, alu_b, alu_cmd, alu_en,
        input  alu_y,
        output res_valid, res_a, res_b, res_cmd, res_y,
        input  res_ready
    );

    modport slave (
        input  alu_a, alu_b, alu_cmd, alu_en,
        output alu_y,
        input  res_valid, res_a, res_b, res_cmd, res_y,
        output res_ready
    );
endinterface

// File: rtl/alu_sweep_cnt.sv
// Nested sweep counter: cmd innermost, then b, then a, each wrapping to zero.
module alu_sweep_cnt #(
    parameter int A_W       = 8,
    parameter int CMD_W     = 4,
    parameter int SWEEP_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [A_W-1:0]   a,
    output logic [A_W-1:0]   b,
    output logic [CMD_W-1:0] cmd,
    output logic             last
);
    localparam logic [A_W-1:0]   SMAX = A_W'(SWEEP_MAX);
    localparam logic [CMD_W-1:0] CMAX = {CMD_W{1'b1}};

    logic [A_W-1:0]   a_r, b_r, a_nx_s, b_nx_s;
    logic [CMD_W-1:0] cmd_r, cmd_nx_s;

    // Next vector: clear wins over advance, carries ripple cmd -> b -> a
    always_comb begin
        a_nx_s   = a_r;
        b_nx_s   = b_r;
        cmd_nx_s = cmd_r;
        if (clear) begin
            a_nx_s   = '0;
            b_nx_s   = '0;
            cmd_nx_s = '0;
        end else if (advance) begin
            if (cmd_r != CMAX) begin
                cmd_nx_s = cmd_r + CMD_W'(1);
            end else begin
                cmd_nx_s = '0;
                if (b_r != SMAX) begin
                    b_nx_s = b_r + A_W'(1);
                end else begin
                    b_nx_s = '0;
                    if (a_r != SMAX) begin
                        a_nx_s = a_r + A_W'(1);
                    end else begin
                        a_nx_s = '0;
                    end
                end
            end
        end else begin
            cmd_nx_s = cmd_r;
        end
    end

    // Vector registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            cmd_r <= '0;
        end else begin
            a_r   <= a_nx_s;
            b_r   <= b_nx_s;
            cmd_r <= cmd_nx_s;
        end
    end

    assign a    = a_r;
    assign b    = b_r;
    assign cmd  = cmd_r;
    assign last = (a_r == SMAX) && (b_r == SMAX) && (cmd_r == CMAX);
endmodule

// File: rtl/alu_sweep_master.sv
// Sweeps every a/b/cmd vector into an ALU and streams the sampled results.
// ALU_SWEEP_CHECK_EN adds a golden-model comparison (mismatch, err_count).
module alu_sweep_master
    import alu_sweep_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int CMD_W     = 4,
    parameter int Y_W       = 16,
    parameter int SWEEP_MAX = 15,
    parameter int SETTLE    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
`ifdef ALU_SWEEP_CHECK_EN
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
`endif
    alu_sweep_master_if.master bus
);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_r, state_nx_s;

    logic [SET_W-1:0] settle_r;
    logic             settle_last_s;
    logic             start_s, capture_s, accept_s;

    logic [A_W-1:0]   vec_a_s, vec_b_s;
    logic [CMD_W-1:0] vec_cmd_s;
    logic             vec_last_s;

    logic             busy_r, done_r, alu_en_r, res_valid_r;
    logic [A_W-1:0]   res_a_r, res_b_r;
    logic [CMD_W-1:0] res_cmd_r;
    logic [Y_W-1:0]   res_y_r;
    logic [CNT_W-1:0] count_r;

    assign settle_last_s = (settle_r == SET_W'(SETTLE - 1));
    assign start_s       = (state_r == ST_IDLE)  && start && !abort;
    assign capture_s     = (state_r == ST_DRIVE) && settle_last_s && !abort;
    // Abort beats a same-cycle handshake, so that result is never counted
    assign accept_s      = (state_r == ST_HOLD)  && bus.res_ready && !abort;

    alu_sweep_cnt #(
        .A_W      (A_W),
        .CMD_W    (CMD_W),
        .SWEEP_MAX(SWEEP_MAX)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_s),
        .advance(accept_s),
        .a      (vec_a_s),
        .b      (vec_b_s),
        .cmd    (vec_cmd_s),
        .last   (vec_last_s)
    );

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_nx_s = ST_DRIVE;
                else                 state_nx_s = ST_IDLE;
            end
            ST_DRIVE: begin
                if (abort)              state_nx_s = ST_IDLE;
                else if (settle_last_s) state_nx_s = ST_HOLD;
                else                    state_nx_s = ST_DRIVE;
            end
            ST_HOLD: begin
                if (abort)              state_nx_s = ST_IDLE;
                else if (bus.res_ready) state_nx_s = vec_last_s ? ST_DONE : ST_DRIVE;
                else                    state_nx_s = ST_HOLD;
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx_s;
    end

    // Settle counter, restarts on every DRIVE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_r <= '0;
        end else if ((state_r == ST_DRIVE) && !settle_last_s && !abort) begin
            settle_r <= settle_r + SET_W'(1);
        end else begin
            settle_r <= '0;
        end
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            alu_en_r    <= 1'b0;
            res_valid_r <= 1'b0;
            res_a_r     <= '0;
            res_b_r     <= '0;
            res_cmd_r   <= '0;
            res_y_r     <= '0;
            count_r     <= '0;
        end else begin
            busy_r      <= (state_nx_s == ST_DRIVE) || (state_nx_s == ST_HOLD);
            alu_en_r    <= (state_nx_s == ST_DRIVE) || (state_nx_s == ST_HOLD);
            res_valid_r <= (state_nx_s == ST_HOLD);
            done_r      <= (state_nx_s == ST_DONE);
            if (capture_s) begin
                res_a_r   <= vec_a_s;
                res_b_r   <= vec_b_s;
                res_cmd_r <= vec_cmd_s;
                res_y_r   <= bus.alu_y;
            end
            if (start_s) begin
                count_r <= '0;
            end else if (accept_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

`ifdef ALU_SWEEP_CHECK_EN
    localparam logic [EXP_W-1:0] AMASK = {{(EXP_W-A_W){1'b0}}, {A_W{1'b1}}};

    logic [Y_W-1:0]   exp_y_s;
    logic             skip_s, mm_s;
    logic             mismatch_r;
    logic [CNT_W-1:0] err_count_r;

    assign exp_y_s = Y_W'(alu_expect(EXP_W'(vec_a_s), EXP_W'(vec_b_s), 4'(vec_cmd_s), AMASK));
    assign skip_s  = (4'(vec_cmd_s) == OP_DIV) && (vec_b_s == '0);
    assign mm_s    = !skip_s && (exp_y_s != bus.alu_y);

    // Mismatch flag travels with the held result; errors counted on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_r  <= 1'b0;
            err_count_r <= '0;
        end else begin
            if (capture_s) begin
                mismatch_r <= mm_s;
            end else if (state_nx_s != ST_HOLD) begin
                mismatch_r <= 1'b0;
            end
            if (start_s) begin
                err_count_r <= '0;
            end else if (accept_s && mismatch_r && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end
        end
    end

    assign mismatch  = mismatch_r;
    assign err_count = err_count_r;
`endif

    assign busy          = busy_r;
    assign done          = done_r;
    assign count         = count_r;
    assign bus.alu_a     = vec_a_s;
    assign bus.alu_b     = vec_b_s;
    assign bus.alu_cmd   = vec_cmd_s;
    assign bus.alu_en    = alu_en_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_a     = res_a_r;
    assign bus.res_b     = res_b_r;
    assign bus.res_cmd   = res_cmd_r;
    assign bus.res_y     = res_y_r;
endmodule

// File: tb/tb_alu_sweep_master.sv
// Randomised scoreboard bench for alu_sweep_master (ALU_SWEEP_CHECK_EN aware).
module tb_alu_sweep_master;
    localparam int A_W = 8, CMD_W = 4, Y_W = 16, SWEEP_MAX = 15, SETTLE = 1, CNT_W = 16;
    localparam int NVEC = 4096;

    logic clk = 1'b0;
    logic rst, start, abort, busy, done;
    logic [CNT_W-1:0] count;
`ifdef ALU_SWEEP_CHECK_EN
    logic mismatch;
    logic [CNT_W-1:0] err_count;
`endif

    alu_sweep_master_if #(.A_W(A_W), .CMD_W(CMD_W), .Y_W(Y_W)) bus ();

    alu_sweep_master #(
        .A_W(A_W), .CMD_W(CMD_W), .Y_W(Y_W),
        .SWEEP_MAX(SWEEP_MAX), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .count(count),
`ifdef ALU_SWEEP_CHECK_EN
        .mismatch(mismatch), .err_count(err_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; the check build plants a wrong ADD 1+1 result
    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
`ifdef ALU_SWEEP_CHECK_EN
        if (c == 4'd0 && a == 8'd1 && b == 8'd1) return 16'd3;
`endif
        case (c)
            4'd0:  return 16'(ai + bi);
            4'd1:  return 16'(ai + 1);
            4'd2:  return 16'(ai - bi);
            4'd3:  return 16'(ai - 1);
            4'd4:  return 16'(ai * bi);
            4'd5:  return (bi == 0) ? 16'hFFFF : 16'(ai / bi);
            4'd6:  return 16'(ai * 2);
            4'd7:  return 16'(ai / 2);
            4'd8:  return {8'h00, a & b};
            4'd9:  return {8'h00, a | b};
            4'd10: return {8'h00, ~a};
            4'd11: return {8'h00, ~(a & b)};
            4'd12: return {8'h00, ~(a | b)};
            4'd13: return {8'h00, a ^ b};
            4'd14: return {8'h00, ~(a ^ b)};
            default: return 16'(ai);
        endcase
    endfunction

    assign bus.alu_y = ref_alu(bus.alu_a, bus.alu_b, bus.alu_cmd);

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  c;
        logic [15:0] y;
        logic        mm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0, errors = 0, done_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int a = 0; a <= SWEEP_MAX; a++)
            for (int b = 0; b <= SWEEP_MAX; b++)
                for (int c = 0; c < 16; c++) begin
                    e.a  = 8'(a);
                    e.b  = 8'(b);
                    e.c  = 4'(c);
                    e.y  = ref_alu(8'(a), 8'(b), 4'(c));
                    e.mm = (a == 1 && b == 1 && c == 0);
                    sbq.push_back(e);
                end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result is compared with the head of the queue
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready && !abort) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got a=%0d b=%0d cmd=%0d y=%0d with nothing expected",
                         bus.res_a, bus.res_b, bus.res_cmd, bus.res_y);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.res_a !== mon_e.a || bus.res_b !== mon_e.b ||
                    bus.res_cmd !== mon_e.c || bus.res_y !== mon_e.y) begin
                    errors++;
                    $display("FAIL result: got a=%0d b=%0d cmd=%0d y=%0d expected a=%0d b=%0d cmd=%0d y=%0d",
                             bus.res_a, bus.res_b, bus.res_cmd, bus.res_y,
                             mon_e.a, mon_e.b, mon_e.c, mon_e.y);
                end
`ifdef ALU_SWEEP_CHECK_EN
                checks++;
                if (mismatch !== mon_e.mm) begin
                    errors++;
                    $display("FAIL mismatch_flag: got %0d expected %0d at a=%0d b=%0d cmd=%0d",
                             mismatch, mon_e.mm, mon_e.a, mon_e.b, mon_e.c);
                end
`endif
            end
            if (bus.res_a == 8'd3 && bus.res_b == 8'd5 && bus.res_cmd == 4'd4) begin
                checks++;
                if (bus.res_y !== 16'd15) begin
                    errors++;
                    $display("FAIL mul_3x5: got %0d expected 15", bus.res_y);
                end
            end
        end
        if (done) done_pulses++;
    end

    initial begin
        int ncyc;
        bit held;
        rst = 1'b1; start = 1'b0; abort = 1'b0; bus.res_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_alu_en", bus.alu_en, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_alu_vec", {bus.alu_a, bus.alu_b, bus.alu_cmd}, 0);
        rst = 1'b0;
        cyc();

        // Full sweep, consumer always ready
        push_sweep();
        bus.res_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_alu_en", bus.alu_en, 1);
        ncyc = 0;
        while (!done && ncyc < 20000) begin
            cyc();
            ncyc++;
        end
        chk("sweep_cycles", ncyc, 8192);
        chk("sweep_done", done, 1);
        chk("sweep_count", count, NVEC);
        chk("sweep_busy_at_done", busy, 0);
        chk("sweep_alu_en_at_done", bus.alu_en, 0);
        chk("sweep_all_results", sbq.size(), 0);
`ifdef ALU_SWEEP_CHECK_EN
        chk("sweep_err_count", err_count, 1);
`endif
        repeat (3) cyc();
        chk("done_one_pulse", done_pulses, 1);
        chk("count_holds", count, NVEC);

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_alu_en", bus.alu_en, 0);
        cyc();
        chk("idle_abort_busy2", busy, 0);
        chk("idle_abort_count", count, NVEC);

        // Abort in HOLD at vector index 100
        push_sweep();
        done_pulses = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_count_clear", count, 0);
        ncyc = 0;
        while (!(bus.res_valid && count == 16'd100) && ncyc < 1000) begin
            cyc();
            ncyc++;
        end
        chk("abort_point_reached", bus.res_valid && count == 16'd100, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_alu_en", bus.alu_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 100);
        chk("abort_results_taken", sbq.size(), NVEC - 100);
        repeat (5) cyc();
        chk("abort_no_done", done_pulses, 0);
        chk("abort_count_frozen", count, 100);
        sbq.delete();

        // Reset while driving vector 37
        push_sweep();
        start = 1'b1;
        cyc();
        start = 1'b0;
        ncyc = 0;
        while (!(!bus.res_valid && bus.alu_en && count == 16'd37) && ncyc < 1000) begin
            cyc();
            ncyc++;
        end
        chk("rst_point_reached", bus.alu_en && count == 16'd37, 1);
        rst = 1'b1;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_alu_en", bus.alu_en, 0);
        chk("midrst_alu_vec", {bus.alu_a, bus.alu_b, bus.alu_cmd}, 0);
        chk("midrst_count", count, 0);
        chk("midrst_res", {bus.res_valid, bus.res_a, bus.res_b, bus.res_cmd, bus.res_y}, 0);
        sbq.delete();
        cyc();
        rst = 1'b0;
        cyc();

        // Random backpressure, stray start pulses, long stall at 7/2 DIV
        push_sweep();
        done_pulses = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        held = 1'b0;
        ncyc = 0;
        while (!done && ncyc < 60000) begin
            if (!held && bus.res_valid && bus.res_a == 8'd7 && bus.res_b == 8'd2 && bus.res_cmd == 4'd5) begin
                bus.res_ready = 1'b0;
                start = 1'b0;
                held = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    cyc();
                    ncyc++;
                    chk("stall_valid", bus.res_valid, 1);
                    chk("stall_vec", {bus.res_a, bus.res_b, bus.res_cmd}, {8'd7, 8'd2, 4'd5});
                    chk("stall_y", bus.res_y, 3);
                end
                bus.res_ready = 1'b1;
            end else begin
                bus.res_ready = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 99) == 0);
            end
            cyc();
            ncyc++;
        end
        start = 1'b0;
        chk("bp_stall_seen", held, 1);
        chk("bp_done", done, 1);
        chk("bp_count", count, NVEC);
        chk("bp_all_results", sbq.size(), 0);
`ifdef ALU_SWEEP_CHECK_EN
        chk("bp_err_count", err_count, 1);
`endif
        repeat (3) cyc();
        chk("bp_done_one_pulse", done_pulses, 1);
        chk("bp_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
